// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings for the calculator command sequencer.
// Status codes, key/command codes and the sequencer state type.
package calc_pkg;

  localparam logic [1:0] CALC_ERR   = 2'b00;
  localparam logic [1:0] CALC_BUSY  = 2'b01;
  localparam logic [1:0] CALC_READY = 2'b10;

  localparam logic [3:0] CMD_ADD  = 4'hA;
  localparam logic [3:0] CMD_SUB  = 4'hB;
  localparam logic [3:0] CMD_MUL  = 4'hC;
  localparam logic [3:0] CMD_EQ   = 4'hE;
  localparam logic [3:0] CMD_BKSP = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE_W,
    WAIT_DONE,
    RECOVER,
    ERROR
  } seq_state_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// calc_cmd_fifo: DEPTH-entry key FIFO, 4-bit data, no bypass.
// Ports: clock, reset_n, push/wdata, pop/rdata, flush, full, empty, level.
module calc_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [3:0]               wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [3:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  assign rdata = mem[rptr];

  // flush drops both a concurrent push and a concurrent pop
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (!do_push && do_pop)
        level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: queues keypad codes and issues them to the calculator
// datapath one at a time, tracking '=' completion and recovering on errors.
// Ports: clock/reset_n; key_valid/key_code/key_ready in; calc_cmd,
// calc_cmd_valid, calc_rst out; calc_status in; err_clr in; busy, err,
// key_drop, level out.
// Build option: CALC_SEQ_AUTO_RECOVER_EN returns to IDLE after a recovery
// instead of parking in ERROR until err_clr.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  output logic                   key_ready,
  output logic [3:0]             calc_cmd,
  output logic                   calc_cmd_valid,
  input  logic [1:0]             calc_status,
  output logic                   calc_rst,
  input  logic                   err_clr,
  output logic                   busy,
  output logic                   err,
  output logic                   key_drop,
  output logic [$clog2(DEPTH):0] level
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT - 1);

  seq_state_t    state;
  logic [SW-1:0] set_cnt;
  logic [WW-1:0] wd;
  logic [3:0]    head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          flush;
  logic          to_rec;

  assign key_ready = !full;
  assign pop       = state == ISSUE;
  assign flush     = state == RECOVER;

  calc_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (key_valid),
    .wdata   (key_code),
    .pop     (pop),
    .flush   (flush),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // a ready status in WAIT_DONE beats both error and watchdog expiry
  always_comb begin
    to_rec = 1'b0;
    unique case (state)
      IDLE, SETTLE_W:
        to_rec = calc_status == CALC_ERR;
      WAIT_DONE:
        to_rec = calc_status != CALC_READY &&
                 (calc_status == CALC_ERR || wd == WD_MAX);
      default:
        to_rec = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      calc_cmd       <= '0;
      calc_cmd_valid <= 1'b0;
      calc_rst       <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
      set_cnt        <= '0;
      wd             <= '0;
    end else begin
      calc_cmd_valid <= 1'b0;
      calc_rst       <= 1'b0;
      // a later set of err in this block overrides the clear
      if (err_clr) err <= 1'b0;
      if (to_rec) begin
        state    <= RECOVER;
        calc_rst <= 1'b1;
        err      <= 1'b1;
        busy     <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (!empty && calc_status == CALC_READY) begin
              state          <= ISSUE;
              calc_cmd       <= head;
              calc_cmd_valid <= 1'b1;
              busy           <= 1'b1;
            end
          end
          ISSUE: begin
            if (calc_cmd == CMD_EQ) begin
              state <= WAIT_DONE;
              wd    <= '0;
            end else begin
              state   <= SETTLE_W;
              set_cnt <= '0;
            end
          end
          SETTLE_W: begin
            if (set_cnt == SET_MAX) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              set_cnt <= set_cnt + 1'b1;
            end
          end
          WAIT_DONE: begin
            if (calc_status == CALC_READY) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          RECOVER: begin
`ifdef CALC_SEQ_AUTO_RECOVER_EN
            state <= IDLE;
            busy  <= 1'b0;
`else
            state <= ERROR;
`endif
          end
          ERROR: begin
            if (err_clr) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      key_drop <= 1'b0;
    else if (key_valid && !key_ready)
      key_drop <= 1'b1;
    else if (err_clr)
      key_drop <= 1'b0;
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer.
// Directed scenarios plus randomized keys/status against a queue model.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int DEPTH   = 8;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 1024;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic [1:0]    calc_status = CALC_BUSY;
  logic          err_clr = 1'b0;
  logic          key_ready;
  logic [3:0]    calc_cmd;
  logic          calc_cmd_valid;
  logic          calc_rst;
  logic          busy;
  logic          err;
  logic          key_drop;
  logic [LW-1:0] level;

  calc_sequencer #(
    .DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_ready      (key_ready),
    .calc_cmd       (calc_cmd),
    .calc_cmd_valid (calc_cmd_valid),
    .calc_status    (calc_status),
    .calc_rst       (calc_rst),
    .err_clr        (err_clr),
    .busy           (busy),
    .err            (err),
    .key_drop       (key_drop),
    .level          (level)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clock) cyc = cyc + 1;

  // reference: FIFO contents as a plain queue, plus occupancy and drop flag
  logic [3:0] exp_q[$];
  int mdl_lvl = 0;
  bit mdl_drop = 1'b0;
  int nstrobe = 0;
  int nrst = 0;
  int last_rst_cyc = -1;
  int last_strobe = -1000;
  bit last_was_eq = 1'b1;
  int strobe_cyc[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      mdl_lvl = 0;
      mdl_drop = 1'b0;
      last_was_eq = 1'b1;
    end else begin
      bit push_ok;
      chk("level", 32'(level), 32'(mdl_lvl));
      chk("key_ready", 32'(key_ready), 32'(mdl_lvl < DEPTH));
      chk("key_drop", 32'(key_drop), 32'(mdl_drop));
      chk("rst_with_valid", 32'(calc_rst & calc_cmd_valid), 32'd0);
      if (calc_cmd_valid) begin
        nstrobe++;
        strobe_cyc.push_back(cyc);
        chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          chk("cmd_order", 32'(calc_cmd), 32'(exp_q.pop_front()));
        if (!last_was_eq)
          chk("spacing_min", 32'((cyc - last_strobe) >= SETTLE + 2), 32'd1);
        last_strobe = cyc;
        last_was_eq = calc_cmd == CMD_EQ;
      end
      push_ok = key_valid && mdl_lvl < DEPTH;
      if (key_valid && !push_ok)
        mdl_drop = 1'b1;
      else if (err_clr)
        mdl_drop = 1'b0;
      if (calc_rst) begin
        nrst++;
        last_rst_cyc = cyc;
        mdl_lvl = 0;
        exp_q.delete();
      end else begin
        mdl_lvl = mdl_lvl + int'(push_ok) - int'(calc_cmd_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_key(logic [3:0] k);
    tick();
    key_valid = 1'b1;
    key_code = k;
    if (mdl_lvl < DEPTH) exp_q.push_back(k);
  endtask

  task automatic idle();
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic wait_strobes(string name, int target, int budget);
    int n = 0;
    while (nstrobe < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(nstrobe >= target), 32'd1);
  endtask

  task automatic wait_valid(string name, int budget);
    int n = 0;
    while (!calc_cmd_valid && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(calc_cmd_valid), 32'd1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_calc_cmd"}, 32'(calc_cmd), 32'd0);
    chk({tag, "_valid"}, 32'(calc_cmd_valid), 32'd0);
    chk({tag, "_calc_rst"}, 32'(calc_rst), 32'd0);
    chk({tag, "_key_ready"}, 32'(key_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_key_drop"}, 32'(key_drop), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    int c0, n0, r0, ts;
    logic [3:0] keys [15];
    logic [3:0] seq [5];
    keys = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
             4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};
    seq = '{4'h1, 4'h2, 4'hA, 4'h3, 4'hE};

    repeat (3) tick();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // sequence 1,2,A,3,E with datapath always ready
    calc_status = CALC_READY;
    strobe_cyc.delete();
    n0 = nstrobe;
    send_key(seq[0]);
    c0 = cyc;
    for (int i = 1; i < 5; i++) send_key(seq[i]);
    idle();
    wait_strobes("seq_strobes", n0 + 5, 80);
    chk("seq_busy_wait", 32'(busy), 32'd1);
    if (strobe_cyc.size() == 5) begin
      chk("seq_latency", 32'(strobe_cyc[0] - c0), 32'd2);
      for (int i = 1; i < 5; i++)
        chk("seq_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]),
            32'(SETTLE + 2));
      chk("seq_e_time", 32'(cyc - strobe_cyc[4]), 32'd1);
    end
    tick();
    chk("seq_busy_done", 32'(busy), 32'd0);

    // overflow with datapath busy
    calc_status = CALC_BUSY;
    n0 = nstrobe;
    for (int i = 0; i < 9; i++) send_key(4'(i));
    idle();
    repeat (2) tick();
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_key_ready", 32'(key_ready), 32'd0);
    chk("ovf_key_drop", 32'(key_drop), 32'd1);
    chk("ovf_no_strobe", 32'(nstrobe), 32'(n0));
    pulse_clr();
    calc_status = CALC_READY;
    wait_strobes("ovf_drain", n0 + 8, 200);

    // watchdog expiry after E
    repeat (2) tick();
    r0 = nrst;
    send_key(CMD_EQ);
    idle();
    wait_valid("to_issue", 40);
    calc_status = CALC_BUSY;
    ts = cyc;
    send_key(4'h3);
    idle();
    repeat (TIMEOUT + 5) tick();
    chk("to_rst_count", 32'(nrst - r0), 32'd1);
    chk("to_rst_time", 32'(last_rst_cyc - ts), 32'(TIMEOUT + 1));
    chk("to_err", 32'(err), 32'd1);
    chk("to_level", 32'(level), 32'd0);
`ifdef CALC_SEQ_AUTO_RECOVER_EN
    chk("to_busy_auto", 32'(busy), 32'd0);
`else
    chk("to_busy_error", 32'(busy), 32'd1);
`endif
    calc_status = CALC_READY;
    pulse_clr();
    tick();
    chk("to_err_clr", 32'(err), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);

    // datapath error while waiting on E
    r0 = nrst;
    send_key(CMD_EQ);
    idle();
    wait_valid("er_issue", 40);
    calc_status = CALC_ERR;
    tick();
    tick();
    calc_status = CALC_READY;
    repeat (2) tick();
    chk("er_rst_count", 32'(nrst - r0), 32'd1);
    chk("er_err", 32'(err), 32'd1);
    n0 = nstrobe;
    send_key(4'h5);
    send_key(4'h6);
    idle();
`ifdef CALC_SEQ_AUTO_RECOVER_EN
    wait_strobes("er_auto_56", n0 + 2, 40);
    send_key(4'h7);
    idle();
    wait_strobes("er_auto_7", n0 + 3, 40);
    pulse_clr();
`else
    repeat (8) tick();
    chk("er_no_strobe", 32'(nstrobe), 32'(n0));
    chk("er_level", 32'(level), 32'd2);
    chk("er_busy", 32'(busy), 32'd1);
    pulse_clr();
    wait_strobes("er_after_clr", n0 + 2, 40);
`endif
    repeat (6) tick();
    chk("er_err_cleared", 32'(err), 32'd0);

    // randomized keys and status
    r0 = nrst;
    for (int i = 0; i < 400; i++) begin
      int s;
      tick();
      key_valid = 1'($urandom_range(0, 1));
      key_code = keys[$urandom_range(0, 14)];
      if (key_valid && mdl_lvl < DEPTH) exp_q.push_back(key_code);
      s = $urandom_range(0, 9);
      calc_status = (s < 6) ? CALC_READY : (s < 9) ? CALC_BUSY : 2'b11;
    end
    idle();
    calc_status = CALC_READY;
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
        tick();
        n++;
      end
    end
    repeat (8) tick();
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    chk("rnd_level", 32'(level), 32'd0);
    chk("rnd_no_rst", 32'(nrst), 32'(r0));
    pulse_clr();

    // reset asserted while a command is being issued
    send_key(4'h4);
    idle();
    wait_valid("rs_issue", 40);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rs_async");
    tick();
    reset_n = 1'b1;
    n0 = nstrobe;
    repeat (6) tick();
    chk("rs_no_strobe", 32'(nstrobe), 32'(n0));
    send_key(4'h8);
    idle();
    wait_strobes("rs_new_key", n0 + 1, 40);
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
